ctrl_sequencer: RTL and testbench
=================================

Name: ctrl_sequencer

Overview:
Parametrised multi-cycle instruction sequencer for the 16-bit MSP-style datapath. It is the successor to the existing fixed fetch/decode FSM. It accepts instructions from fetch over a valid/ready handshake, decodes double-operand, single-operand and jump formats, and evaluates jump conditions against the ALU status flags. It drives the PC mux, register bank and ALU opcode, supports ALU stalls and flags illegal encodings.

Parameters:
REG_AW, 4, register address width (src_reg/dst_reg/wr_reg)
OP_W, 5, ALU opcode width
PC_W, 16, width of pc_offset output
OFF_SHIFT, 1, left shift applied to the sign-extended jump offset (word addressing)
NOP_CODE, 5'h1F, op_code driven for jumps, illegal instructions and idle states
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  system clock, all flops on rising edge
rst  in  1  asynchronous, active-low reset (assert 0 = reset)
instruction  in  16  instruction word from fetch
inst_valid  in  1  instruction word is valid
inst_ready  out  1  sequencer can accept an instruction
flags  in  4  {V,N,C,Z} ALU status
alu_busy  in  1  ALU needs more cycles; holds EXEC
en_pc_2  out  1  PC mux selects PC+2
pc_inc  out  1  PC register load enable
branch_en  out  1  PC mux selects PC+pc_offset
pc_offset  out  PC_W  sign-extended, shifted jump offset
wr_en  out  1  register bank write strobe
src_reg  out  REG_AW  source register
dst_reg  out  REG_AW  destination register
wr_reg  out  REG_AW  write-back register
op_code  out  OP_W  ALU operation
addr_mode  out  4  instruction[7:4] of double-op instructions, else 0
illegal_inst  out  1  one-cycle pulse on an illegal encoding
fsm_state  out  5  one-hot state
retired_cnt  out  CNT_W  count of completed legal instructions

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; captured instruction=0.
  - All outputs 0, except op_code=NOP_CODE and fsm_state=00001.
  - retired_cnt=0.
  - Reset mid-instruction aborts it; no wr_en and no branch_en follow.
- States, one-hot fsm_state: IDLE=00001, FETCH=00010, DECODE=00100, EXEC=01000, WB=10000.
- IDLE:
  - Lasts one cycle, then FETCH.
- FETCH:
  - inst_ready=1; all other strobes are 0.
  - On the edge where inst_valid & inst_ready are both 1: capture instruction, go to DECODE.
  - If inst_valid=0, stay in FETCH.
- DECODE:
  - en_pc_2=1 and pc_inc=1 for exactly one cycle (PC+=2).
  - Decoded fields are registered here and held until the next capture.
  - Illegal encoding: illegal_inst=1 this cycle, op_code=NOP_CODE, next state FETCH. No EXEC, no WB, no count.
- Decode rules, opc=instruction[15:12]:
  - opc 4..F, double-op: op_code=opc-4 (0..11); src_reg=[11:8]; dst_reg=wr_reg=[3:0]; addr_mode=[7:4]. Writes back unless opc=9 (CMP) or opc=B (BIT).
  - opc 1, single-op: sg=[11:6]; dst_reg=wr_reg=[3:0], except PUSH/PUSH.B which use src_reg=[3:0].
    - sg 0,1,2,4,5,6 → op_code 10h..15h (RRC, RRC.B, SWPB, RRA, RRA.B, SXT); these write back.
    - sg 8,9,10,12 → op_code 16h..19h (PUSH, PUSH.B, CALL, RETI); these do not write back.
    - Any other sg value is illegal.
  - opc 2/3, jump: cond={instruction[12],[11:10]}; op_code=NOP_CODE.
    - pc_offset = sign_extend([9:0]) << OFF_SHIFT, truncated/extended to PC_W.
  - opc 0: illegal.
- EXEC:
  - op_code is presented to the ALU.
  - While alu_busy=1, stay in EXEC with all strobes 0.
  - Flags are sampled in the EXEC cycle with alu_busy=0 (the exit cycle).
  - Jump, exit cycle: branch_en=1 and pc_inc=1 if the condition is true, otherwise both 0. Next state FETCH; retired_cnt+1.
  - Jump conditions: 000 Z=0; 001 Z=1; 010 C=0; 011 C=1; 100 N=1; 101 N^V=0; 110 N^V=1; 111 always.
  - Non-jump: next state WB.
- WB:
  - wr_en=1 for one cycle for write-back ops, else 0.
  - retired_cnt+1; next state FETCH.
- Latency from acceptance edge: DECODE +1, EXEC +2, WB +3, FETCH +4 (no stall). Jumps return to FETCH at +3.
- retired_cnt wraps from all-ones to 0.
- A reset and a clock edge arriving together: reset wins.

Test Plan:
- Reset release, ADD 5A34h with inst_valid held → accepted on 2nd edge; DECODE: en_pc_2=pc_inc=1; EXEC: op_code=01h, src=Ah, dst=4h; WB: wr_en=1, wr_reg=4h; retired_cnt=1.
- JEQ 2405h with flags Z=1 → EXEC: branch_en=1, pc_inc=1, pc_offset=000Ah. Repeat with Z=0 → branch_en=0, pc_inc=0. No WB either time.
- JMP 3FFFh (offset −1) → pc_offset=FFFEh, branch_en=1 for any flags. JL 3805h with N=1, V=0 → branch_en=1; with N=V=1 → branch_en=0.
- CMP 9123h → op_code=05h, WB state visited, wr_en stays 0. RRA 1105h → op_code=13h, wr_reg=5h, wr_en=1.
- Illegal 0123h and 10C5h (sg=3) → illegal_inst pulse in DECODE, back in FETCH one cycle later, retired_cnt unchanged, wr_en never asserted.
- SUB 7213h with alu_busy=1 for 3 EXEC cycles → EXEC held 4 cycles, then WB. Pull rst=0 during the 2nd EXEC cycle → immediate IDLE, all outputs reset, no wr_en.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// Multi-cycle instruction sequencer for the 16-bit MSP-style datapath: handshakes
// instructions from fetch, decodes, steps EXEC/WB and resolves jump conditions.
module ctrl_sequencer #(
   parameter int unsigned      REG_AW    = 4,
   parameter int unsigned      OP_W      = 5,
   parameter int unsigned      PC_W      = 16,
   parameter int unsigned      OFF_SHIFT = 1,
   parameter logic [OP_W-1:0]  NOP_CODE  = OP_W'(5'h1F),
   parameter int unsigned      CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       instruction,
   input  logic              inst_valid,
   output logic              inst_ready,
   input  logic [3:0]        flags,
   input  logic              alu_busy,
   output logic              en_pc_2,
   output logic              pc_inc,
   output logic              branch_en,
   output logic [PC_W-1:0]   pc_offset,
   output logic              wr_en,
   output logic [REG_AW-1:0] src_reg,
   output logic [REG_AW-1:0] dst_reg,
   output logic [REG_AW-1:0] wr_reg,
   output logic [OP_W-1:0]   op_code,
   output logic [3:0]        addr_mode,
   output logic              illegal_inst,
   output logic [4:0]        fsm_state,
   output logic [CNT_W-1:0]  retired_cnt
);

   typedef enum logic [4:0] {
      S_IDLE   = 5'b00001,
      S_FETCH  = 5'b00010,
      S_DECODE = 5'b00100,
      S_EXEC   = 5'b01000,
      S_WB     = 5'b10000
   } state_t;

   state_t              state_q, state_d;
   logic [15:0]         instr_q;
   logic [OP_W-1:0]     op_q;
   logic [REG_AW-1:0]   src_q, dst_q, wr_q;
   logic [3:0]          am_q;
   logic [PC_W-1:0]     off_q;
   logic [2:0]          cond_q;
   logic                jump_q, wb_q;
   logic [CNT_W-1:0]    cnt_q;

   logic                capture, latch_fields, cnt_inc;

   logic [3:0]          opc;
   logic [5:0]          sg;
   logic                dec_legal, dec_jump, dec_wb;
   logic [OP_W-1:0]     dec_op;
   logic [REG_AW-1:0]   dec_src, dec_dst, dec_wr;
   logic [3:0]          dec_am;
   logic [PC_W-1:0]     dec_off;
   logic [2:0]          dec_cond;
   logic                taken;

   // Combinational decode of the captured word; results are latched on DECODE exit.
   always_comb begin
      opc       = instr_q[15:12];
      sg        = instr_q[11:6];
      dec_legal = 1'b0;
      dec_jump  = 1'b0;
      dec_wb    = 1'b0;
      dec_op    = NOP_CODE;
      dec_src   = '0;
      dec_dst   = '0;
      dec_wr    = '0;
      dec_am    = '0;
      dec_off   = '0;
      dec_cond  = '0;
      if (opc >= 4'd4) begin
         dec_legal = 1'b1;
         dec_op    = OP_W'(opc - 4'd4);
         dec_src   = REG_AW'(instr_q[11:8]);
         dec_dst   = REG_AW'(instr_q[3:0]);
         dec_wr    = REG_AW'(instr_q[3:0]);
         dec_am    = instr_q[7:4];
         dec_wb    = (opc != 4'h9) && (opc != 4'hB);
      end else if (opc == 4'h1) begin
         dec_legal = 1'b1;
         dec_dst   = REG_AW'(instr_q[3:0]);
         dec_wr    = REG_AW'(instr_q[3:0]);
         case (sg)
            6'd0:  begin dec_op = OP_W'(5'h10); dec_wb = 1'b1; end
            6'd1:  begin dec_op = OP_W'(5'h11); dec_wb = 1'b1; end
            6'd2:  begin dec_op = OP_W'(5'h12); dec_wb = 1'b1; end
            6'd4:  begin dec_op = OP_W'(5'h13); dec_wb = 1'b1; end
            6'd5:  begin dec_op = OP_W'(5'h14); dec_wb = 1'b1; end
            6'd6:  begin dec_op = OP_W'(5'h15); dec_wb = 1'b1; end
            6'd8, 6'd9: begin
               dec_op  = (sg == 6'd8) ? OP_W'(5'h16) : OP_W'(5'h17);
               dec_src = REG_AW'(instr_q[3:0]);
               dec_dst = '0;
               dec_wr  = '0;
            end
            6'd10: dec_op = OP_W'(5'h18);
            6'd12: dec_op = OP_W'(5'h19);
            default: begin
               dec_legal = 1'b0;
               dec_dst   = '0;
               dec_wr    = '0;
            end
         endcase
      end else if (opc == 4'h2 || opc == 4'h3) begin
         dec_legal = 1'b1;
         dec_jump  = 1'b1;
         dec_cond  = {instr_q[12], instr_q[11:10]};
         dec_off   = PC_W'($signed(instr_q[9:0])) << OFF_SHIFT;
      end
   end

   // flags = {V,N,C,Z}
   always_comb begin
      taken = 1'b0;
      case (cond_q)
         3'b000: taken = ~flags[0];
         3'b001: taken =  flags[0];
         3'b010: taken = ~flags[1];
         3'b011: taken =  flags[1];
         3'b100: taken =  flags[2];
         3'b101: taken = ~(flags[2] ^ flags[3]);
         3'b110: taken =   flags[2] ^ flags[3];
         default: taken = 1'b1;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      inst_ready   = 1'b0;
      en_pc_2      = 1'b0;
      pc_inc       = 1'b0;
      branch_en    = 1'b0;
      wr_en        = 1'b0;
      illegal_inst = 1'b0;
      op_code      = NOP_CODE;
      capture      = 1'b0;
      latch_fields = 1'b0;
      cnt_inc      = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            inst_ready = 1'b1;
            if (inst_valid) begin
               capture = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            en_pc_2 = 1'b1;
            pc_inc  = 1'b1;
            if (dec_legal) begin
               latch_fields = 1'b1;
               state_d      = S_EXEC;
            end else begin
               illegal_inst = 1'b1;
               state_d      = S_FETCH;
            end
         end
         S_EXEC: begin
            op_code = jump_q ? NOP_CODE : op_q;
            if (!alu_busy) begin
               if (jump_q) begin
                  branch_en = taken;
                  pc_inc    = taken;
                  cnt_inc   = 1'b1;
                  state_d   = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            op_code = op_q;
            wr_en   = wb_q;
            cnt_inc = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         instr_q <= '0;
         op_q    <= NOP_CODE;
         src_q   <= '0;
         dst_q   <= '0;
         wr_q    <= '0;
         am_q    <= '0;
         off_q   <= '0;
         cond_q  <= '0;
         jump_q  <= 1'b0;
         wb_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (capture) instr_q <= instruction;
         if (latch_fields) begin
            op_q   <= dec_op;
            src_q  <= dec_src;
            dst_q  <= dec_dst;
            wr_q   <= dec_wr;
            am_q   <= dec_am;
            off_q  <= dec_off;
            cond_q <= dec_cond;
            jump_q <= dec_jump;
            wb_q   <= dec_wb;
         end
         if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign src_reg     = src_q;
   assign dst_reg     = dst_q;
   assign wr_reg      = wr_q;
   assign addr_mode   = am_q;
   assign pc_offset   = off_q;
   assign fsm_state   = state_q;
   assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: directed scenarios plus random instruction
// streams compared against a table-driven reference decoder and cycle timeline.
module tb_ctrl_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] instruction;
   logic        inst_valid;
   logic        inst_ready;
   logic [3:0]  flags;
   logic        alu_busy;
   logic        en_pc_2, pc_inc, branch_en, wr_en, illegal_inst;
   logic [15:0] pc_offset;
   logic [3:0]  src_reg, dst_reg, wr_reg, addr_mode;
   logic [4:0]  op_code;
   logic [4:0]  fsm_state;
   logic [15:0] retired_cnt;

   int checks   = 0;
   int failures = 0;
   int exp_cnt  = 0;

   localparam logic [4:0] ST_IDLE = 5'b00001, ST_FETCH = 5'b00010, ST_DECODE = 5'b00100,
                          ST_EXEC = 5'b01000, ST_WB = 5'b10000;
   localparam logic [4:0] NOP = 5'h1F;

   int sg_list[10] = '{0, 1, 2, 4, 5, 6, 8, 9, 10, 12};

   always #5 clk = ~clk;

   ctrl_sequencer #(.REG_AW(4), .OP_W(5), .PC_W(16), .OFF_SHIFT(1), .NOP_CODE(5'h1F), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .instruction(instruction), .inst_valid(inst_valid),
      .inst_ready(inst_ready), .flags(flags), .alu_busy(alu_busy), .en_pc_2(en_pc_2),
      .pc_inc(pc_inc), .branch_en(branch_en), .pc_offset(pc_offset), .wr_en(wr_en),
      .src_reg(src_reg), .dst_reg(dst_reg), .wr_reg(wr_reg), .op_code(op_code),
      .addr_mode(addr_mode), .illegal_inst(illegal_inst), .fsm_state(fsm_state),
      .retired_cnt(retired_cnt)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic ref_decode(input logic [15:0] ins, output bit legal, output bit jump,
                             output bit wb, output bit push, output bit dbl,
                             output logic [4:0] op, output logic [3:0] src,
                             output logic [3:0] dst, output logic [3:0] am,
                             output logic [15:0] off, output logic [2:0] cond);
      int opc = int'(ins[15:12]);
      int sg  = int'(ins[11:6]);
      int soff;
      legal = 0; jump = 0; wb = 0; push = 0; dbl = 0;
      op = NOP; src = 0; dst = 0; am = 0; off = 0; cond = 0;
      if (opc >= 4) begin
         legal = 1; dbl = 1;
         op  = 5'(opc - 4);
         src = ins[11:8]; dst = ins[3:0]; am = ins[7:4];
         wb  = (opc != 9) && (opc != 11);
      end else if (opc == 1) begin
         for (int k = 0; k < 10; k++)
            if (sg_list[k] == sg) begin
               legal = 1;
               op    = 5'(16 + k);
               wb    = (k < 6);
               push  = (k == 6) || (k == 7);
            end
         if (push) src = ins[3:0];
         else dst = ins[3:0];
      end else if (opc == 2 || opc == 3) begin
         legal = 1; jump = 1;
         cond = {ins[12], ins[11:10]};
         soff = ins[9] ? int'(ins[9:0]) - 1024 : int'(ins[9:0]);
         off  = 16'(soff * 2);
      end
   endtask

   function automatic bit ref_taken(input logic [2:0] c, input logic [3:0] f);
      bit v = f[3], n = f[2], cy = f[1], z = f[0];
      case (c)
         3'd0: return !z;
         3'd1: return z;
         3'd2: return !cy;
         3'd3: return cy;
         3'd4: return n;
         3'd5: return n == v;
         3'd6: return n != v;
         default: return 1'b1;
      endcase
   endfunction

   // Drives one instruction from FETCH through retirement, checking every cycle.
   task automatic run_inst(input logic [15:0] ins, input logic [3:0] f, input int busy,
                           input string tag);
      bit legal, jump, wb, push, dbl, tk;
      logic [4:0] op; logic [3:0] src, dst, am; logic [15:0] off; logic [2:0] cond;
      int waits = 0;
      ref_decode(ins, legal, jump, wb, push, dbl, op, src, dst, am, off, cond);
      tk = ref_taken(cond, f);
      while (fsm_state !== ST_FETCH && waits < 10) begin tick; waits++; end
      checks++;
      if (fsm_state !== ST_FETCH || waits != 0) begin
         failures++;
         $display("FAIL %s fetch_entry state=%b waits=%0d exp state=%b waits=0", tag, fsm_state, waits, ST_FETCH);
         if (fsm_state !== ST_FETCH) return;
      end
      instruction = ins; inst_valid = 1'b1; #1;
      checks++;
      if (inst_ready !== 1'b1) begin failures++; $display("FAIL %s inst_ready got=%b exp=1", tag, inst_ready); end
      tick;
      inst_valid = 1'b0; instruction = 16'($urandom); #1;
      checks++;
      if (fsm_state !== ST_DECODE || en_pc_2 !== 1'b1 || pc_inc !== 1'b1 || wr_en !== 1'b0 ||
          branch_en !== 1'b0 || inst_ready !== 1'b0) begin
         failures++;
         $display("FAIL %s decode state=%b en_pc_2=%b pc_inc=%b wr_en=%b br=%b rdy=%b exp state=%b 1 1 0 0 0",
                  tag, fsm_state, en_pc_2, pc_inc, wr_en, branch_en, inst_ready, ST_DECODE);
      end
      checks++;
      if (illegal_inst !== !legal) begin failures++; $display("FAIL %s illegal_inst got=%b exp=%b", tag, illegal_inst, !legal); end
      if (!legal) begin
         checks++;
         if (op_code !== NOP) begin failures++; $display("FAIL %s illegal_op got=%h exp=%h", tag, op_code, NOP); end
         tick;
         checks++;
         if (fsm_state !== ST_FETCH || illegal_inst !== 1'b0 || wr_en !== 1'b0 || retired_cnt !== 16'(exp_cnt)) begin
            failures++;
            $display("FAIL %s illegal_return state=%b ill=%b wr_en=%b cnt=%0d exp state=%b 0 0 cnt=%0d",
                     tag, fsm_state, illegal_inst, wr_en, retired_cnt, ST_FETCH, exp_cnt);
         end
         return;
      end
      tick;
      for (int b = 0; b < busy; b++) begin
         alu_busy = 1'b1; flags = ~f; #1;
         checks++;
         if (fsm_state !== ST_EXEC || pc_inc !== 1'b0 || branch_en !== 1'b0 || wr_en !== 1'b0) begin
            failures++;
            $display("FAIL %s exec_stall%0d state=%b pc_inc=%b br=%b wr_en=%b exp state=%b 0 0 0",
                     tag, b, fsm_state, pc_inc, branch_en, wr_en, ST_EXEC);
         end
         tick;
      end
      alu_busy = 1'b0; flags = f; #1;
      checks++;
      if (fsm_state !== ST_EXEC || op_code !== op || addr_mode !== am) begin
         failures++;
         $display("FAIL %s exec state=%b op=%h am=%h exp state=%b op=%h am=%h", tag, fsm_state, op_code, addr_mode, ST_EXEC, op, am);
      end
      checks++;
      if (jump) begin
         if (branch_en !== tk || pc_inc !== tk || pc_offset !== off) begin
            failures++;
            $display("FAIL %s jump br=%b pc_inc=%b off=%h exp br=%b pc_inc=%b off=%h", tag, branch_en, pc_inc, pc_offset, tk, tk, off);
         end
      end else begin
         if (branch_en !== 1'b0 || pc_inc !== 1'b0 || ((dbl || push) && src_reg !== src) || (!push && dst_reg !== dst)) begin
            failures++;
            $display("FAIL %s regs br=%b pc_inc=%b src=%h dst=%h exp br=0 pc_inc=0 src=%h dst=%h", tag, branch_en, pc_inc, src_reg, dst_reg, src, dst);
         end
      end
      tick;
      flags = 4'($urandom);
      if (!jump) begin
         #1;
         checks++;
         if (fsm_state !== ST_WB || wr_en !== wb || (!push && wr_reg !== dst)) begin
            failures++;
            $display("FAIL %s wb state=%b wr_en=%b wr_reg=%h exp state=%b wr_en=%b wr_reg=%h", tag, fsm_state, wr_en, wr_reg, ST_WB, wb, dst);
         end
         tick;
      end
      exp_cnt = (exp_cnt + 1) & 16'hFFFF;
      checks++;
      if (fsm_state !== ST_FETCH || retired_cnt !== 16'(exp_cnt) || wr_en !== 1'b0) begin
         failures++;
         $display("FAIL %s retire state=%b cnt=%0d wr_en=%b exp state=%b cnt=%0d wr_en=0", tag, fsm_state, retired_cnt, wr_en, ST_FETCH, exp_cnt);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0; instruction = '0; inst_valid = 1'b0; flags = '0; alu_busy = 1'b0;
      tick; tick;
      checks++;
      if (fsm_state !== ST_IDLE || op_code !== NOP || retired_cnt !== 16'd0 || inst_ready !== 1'b0 ||
          en_pc_2 !== 1'b0 || pc_inc !== 1'b0 || branch_en !== 1'b0 || wr_en !== 1'b0 || illegal_inst !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl state=%b op=%h cnt=%0d rdy=%b en2=%b inc=%b br=%b wr=%b ill=%b exp state=00001 op=1f others 0",
                  fsm_state, op_code, retired_cnt, inst_ready, en_pc_2, pc_inc, branch_en, wr_en, illegal_inst);
      end
      checks++;
      if (pc_offset !== 16'd0 || src_reg !== 4'd0 || dst_reg !== 4'd0 || wr_reg !== 4'd0 || addr_mode !== 4'd0) begin
         failures++;
         $display("FAIL reset_fields off=%h src=%h dst=%h wr=%h am=%h exp all 0", pc_offset, src_reg, dst_reg, wr_reg, addr_mode);
      end
      exp_cnt = 0;
      instruction = 16'h5A34; inst_valid = 1'b1;
      #2 rst = 1'b1;
      tick;
      checks++;
      if (fsm_state !== ST_FETCH || inst_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release state=%b rdy=%b exp state=%b rdy=1", fsm_state, inst_ready, ST_FETCH);
      end
   endtask

   task automatic test_add;
      run_inst(16'h5A34, 4'h0, 0, "add");
   endtask

   task automatic test_jumps;
      run_inst(16'h2405, 4'b0001, 0, "jeq_taken");
      run_inst(16'h2405, 4'b0000, 0, "jeq_not");
      run_inst(16'h3FFF, 4'($urandom), 0, "jmp_back1");
      run_inst(16'h3FFF, 4'($urandom), 1, "jmp_back2");
      run_inst(16'h3805, 4'b0100, 0, "jl_taken");
      run_inst(16'h3805, 4'b1100, 0, "jl_not");
   endtask

   task automatic test_single_cmp;
      run_inst(16'h9123, 4'h0, 0, "cmp");
      run_inst(16'h1105, 4'h0, 0, "rra");
      run_inst(16'h1207, 4'h0, 0, "push");
   endtask

   task automatic test_illegal;
      run_inst(16'h0123, 4'h0, 0, "illegal_opc0");
      run_inst(16'h10C5, 4'h0, 0, "illegal_sg3");
   endtask

   task automatic test_stall_reset;
      run_inst(16'h7213, 4'h0, 3, "sub_stall");
      instruction = 16'h7213; inst_valid = 1'b1;
      tick;
      inst_valid = 1'b0;
      tick;
      alu_busy = 1'b1;
      tick;
      checks++;
      if (fsm_state !== ST_EXEC) begin failures++; $display("FAIL abort_pre state=%b exp=%b", fsm_state, ST_EXEC); end
      #2 rst = 1'b0;
      #1;
      exp_cnt = 0;
      checks++;
      if (fsm_state !== ST_IDLE || wr_en !== 1'b0 || op_code !== NOP || retired_cnt !== 16'd0 ||
          src_reg !== 4'd0 || dst_reg !== 4'd0 || wr_reg !== 4'd0 || addr_mode !== 4'd0 || pc_inc !== 1'b0) begin
         failures++;
         $display("FAIL abort_reset state=%b wr=%b op=%h cnt=%0d src=%h dst=%h wrr=%h am=%h inc=%b exp state=00001 op=1f rest 0",
                  fsm_state, wr_en, op_code, retired_cnt, src_reg, dst_reg, wr_reg, addr_mode, pc_inc);
      end
      alu_busy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         checks++;
         if (fsm_state !== ST_IDLE || wr_en !== 1'b0 || branch_en !== 1'b0) begin
            failures++;
            $display("FAIL abort_hold%0d state=%b wr=%b br=%b exp state=00001 0 0", i, fsm_state, wr_en, branch_en);
         end
      end
      #2 rst = 1'b1;
      tick;
      checks++;
      if (fsm_state !== ST_FETCH) begin failures++; $display("FAIL abort_release state=%b exp=%b", fsm_state, ST_FETCH); end
   endtask

   task automatic test_random;
      logic [15:0] ins;
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 4))
            0, 1: ins = {4'($urandom_range(4, 15)), 12'($urandom)};
            2:    ins = {4'h1, 6'(sg_list[$urandom_range(0, 9)]), 6'($urandom)};
            3:    ins = {3'b001, 13'($urandom)};
            default: ins = ($urandom_range(0, 1) == 0) ? {4'h0, 12'($urandom)} : {4'h1, 6'($urandom), 6'($urandom)};
         endcase
         run_inst(ins, 4'($urandom), int'($urandom_range(0, 2)), "rand");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_add;
      test_jumps;
      test_single_cmp;
      test_illegal;
      test_stall_reset;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
